// File: rtl/id_pipe_pkg.sv
// Shared constants, helpers and types for the elastic identity pipeline.
package id_pipe_pkg;

    localparam int MAX_DEPTH     = 16;
    localparam int DEFAULT_WIDTH = 16;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Modules declare their own WIDTH-sized word; this is the default-width form.
    typedef logic signed [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/id_pipe_stage.sv
// One registered identity stage with a valid/ready handshake on each side.
module id_pipe_stage
    import id_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic signed [WIDTH-1:0] up_data,
    input  logic                    up_valid,
    output logic                    up_ready,
    output logic signed [WIDTH-1:0] dn_data,
    output logic                    dn_valid,
    input  logic                    dn_ready
);

    typedef logic signed [WIDTH-1:0] stage_word_t;

    stage_word_t data_p0;
    logic        vld_p0;

    // An empty stage always accepts, so bubbles collapse under backpressure.
    assign up_ready = !vld_p0 || dn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
        end else if (up_valid && up_ready) begin
            vld_p0  <= 1'b1;
            data_p0 <= up_data;
        end else if (dn_ready) begin
            vld_p0 <= 1'b0;
        end
    end

    assign dn_data  = data_p0;
    assign dn_valid = vld_p0;

endmodule

// File: rtl/id_pipe_chain.sv
// DEPTH registered identity stages in series, with flush and occupancy count.
module id_pipe_chain
    import id_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] x,
    input  logic                    x_valid,
    output logic                    x_ready,
    input  logic                    flush,
    output logic signed [WIDTH-1:0] y,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic [CNT_W-1:0]        occupancy
);

    typedef logic signed [WIDTH-1:0] chain_word_t;

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("id_pipe_chain: DEPTH out of range");
    end

    // Index i is the upstream side of stage i; index DEPTH is the output.
    chain_word_t dat [DEPTH+1];
    logic        vld [DEPTH+1];
    logic        rdy [DEPTH+1];

    assign dat[0]     = x;
    assign vld[0]     = x_valid;
    assign rdy[DEPTH] = y_ready;
    assign x_ready    = rdy[0];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        id_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_data  (dat[i]),
            .up_valid (vld[i]),
            .up_ready (rdy[i]),
            .dn_data  (dat[i+1]),
            .dn_valid (vld[i+1]),
            .dn_ready (rdy[i+1])
        );
    end

    assign y       = dat[DEPTH];
    assign y_valid = vld[DEPTH];

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = x_valid && x_ready;
    assign out_xfer = y_valid && y_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occupancy <= occupancy - CNT_W'(1);
        end
    end

endmodule
